regfile_wb_arb: RTL and testbench
=================================

REGFILE_WB_ARB -- requirements
Module: regfile_wb_arb

Interface
REQ-001: Parameter DATA_W SHALL default to 32 and set the write-data width.
REQ-002: Parameter ADDR_W SHALL default to 4 and set the register-address width.
REQ-003: Parameter DEPTH SHALL default to 2 and set the per-source queue depth (power of two, >=2).
REQ-004: Port clk SHALL be an input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-005: Port rst_n SHALL be an input, 1 bit, asynchronous active-low reset.
REQ-006: Port a_valid SHALL be an input, 1 bit, source A writeback request.
REQ-007: Port a_ready SHALL be an output, 1 bit, source A queue can accept.
REQ-008: Port a_addr SHALL be an input, ADDR_W bits, source A destination register.
REQ-009: Port a_data SHALL be an input, DATA_W bits, source A write data.
REQ-010: Ports b_valid (in, 1), b_ready (out, 1), b_addr (in, ADDR_W) and b_data (in, DATA_W) SHALL mirror source A for source B.
REQ-011: Port rd_write SHALL be an output, 1 bit, write strobe to the register file.
REQ-012: Port rd_addr SHALL be an output, ADDR_W bits, register-file write address.
REQ-013: Port rd_wdata SHALL be an output, DATA_W bits, register-file write data.
REQ-014: Port busy SHALL be an output, 1 bit, high while any write is queued or rd_write is high.

Function
REQ-015: Each source SHALL own an in-order FIFO of DEPTH {addr,data} entries.
REQ-016: x_ready SHALL be high iff that FIFO is not full; it SHALL depend only on registered state, never on x_valid.
REQ-017: An entry SHALL be pushed on a rising edge where x_valid and x_ready are both high; x_addr/x_data SHALL be ignored otherwise.
REQ-018: Per edge, the arbiter SHALL pop at most one entry in total from the two FIFOs.
REQ-019: If only one FIFO is non-empty, that FIFO SHALL be granted.
REQ-020: If both are non-empty, the source not granted most recently SHALL be granted (round-robin); the last-grant flag SHALL update only on a grant.
REQ-021: A popped entry SHALL drive rd_addr/rd_wdata with rd_write high for exactly the one cycle following the pop edge.
REQ-022: No bypass: an entry pushed at edge T SHALL be popped no earlier than edge T+1, so rd_write rises no earlier than after edge T+1.
REQ-023: A FIFO popped and pushed on the same edge SHALL keep its count unchanged and preserve order.
REQ-024: A full FIFO SHALL hold x_ready low until a pop; no entry SHALL ever be dropped or overwritten.
REQ-025: When rd_write is low, rd_addr and rd_wdata SHALL hold their last values.
REQ-026: Entries SHALL be forwarded unfiltered, including address 0 and duplicate addresses; final same-address order is the grant order.
REQ-027: Pointers SHALL wrap modulo DEPTH; occupancy SHALL range 0..DEPTH.
REQ-028: Sustained throughput SHALL be one register-file write per cycle whenever any FIFO is non-empty.

Reset
REQ-029: While rst_n is low, rd_write and busy SHALL be 0, rd_addr and rd_wdata 0, both FIFOs empty, and a_ready and b_ready 1.
REQ-030: Reset SHALL set the last-grant flag to B, so A wins the first contested grant.
REQ-031: Reset asserted mid-operation SHALL discard all queued entries immediately, with no rd_write pulse during or after reset.

Verification
REQ-032: A pushes addr=3, data=0xDEADBEEF at edge T with B idle -> rd_write=1, rd_addr=3, rd_wdata=0xDEADBEEF in the cycle after edge T+1 only.
REQ-033: A (addr 1, 0x11) and B (addr 2, 0x22) push on the same edge, after reset -> addr 1 is written, then addr 2 on consecutive cycles.
REQ-034: B holds valid low while A pushes 3 entries back-to-back with DEPTH=2 -> a_ready drops after 2 unpopped pushes, and all 3 writes appear in order, none lost.
REQ-035: Both sources stream continuously for 8 cycles -> rd_write stays high, grants alternate A,B,A,B, and per-source order is preserved.
REQ-036: rst_n is pulsed low with 2 entries queued in each FIFO -> rd_write=0, busy=0, both ready=1 immediately, and no stale write appears after release.
REQ-037: A and B both write addr 5 (A 0x5A, B 0x5B), with last grant = A -> 0x5B is written first and 0x5A last.

Source files
------------

// File: rtl/regfile_wb_arb.sv
// Writeback arbiter that merges two sources into one register-file write port.
// Each source has its own in-order queue. A round-robin arbiter picks one
// entry per cycle and drives it out as a registered write.
module regfile_wb_arb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              rd_write,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_wdata,
    output logic              busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } src_t;

    // Index 0 is source A, index 1 is source B.
    logic [1:0]             in_valid;
    logic [1:0][ADDR_W-1:0] in_addr;
    logic [1:0][DATA_W-1:0] in_data;
    logic [1:0]             ready;
    logic [1:0]             push;
    logic [1:0]             pop;
    logic [1:0]             nonempty;
    logic [1:0][ADDR_W-1:0] head_addr;
    logic [1:0][DATA_W-1:0] head_data;
    src_t                   last_grant;

    assign in_valid = {b_valid, a_valid};
    assign in_addr  = {b_addr, a_addr};
    assign in_data  = {b_data, a_data};
    assign a_ready  = ready[0];
    assign b_ready  = ready[1];
    assign busy     = (|nonempty) | rd_write;

    for (genvar g = 0; g < 2; g++) begin : g_fifo
        logic [ADDR_W-1:0] addr_mem [DEPTH];
        logic [DATA_W-1:0] data_mem [DEPTH];
        logic [PTR_W-1:0]  wptr;
        logic [PTR_W-1:0]  rptr;
        logic [CNT_W-1:0]  cnt;

        // Ready and non-empty come only from the registered count.
        assign nonempty[g]  = (cnt != '0);
        assign ready[g]     = (cnt != CNT_W'(DEPTH));
        assign push[g]      = in_valid[g] & ready[g];
        assign head_addr[g] = addr_mem[rptr];
        assign head_data[g] = data_mem[rptr];

        // Storage write; contents need no reset since the count gates reads.
        always_ff @(posedge clk) begin
            if (push[g]) begin
                addr_mem[wptr] <= in_addr[g];
                data_mem[wptr] <= in_data[g];
            end
        end

        // Pointers wrap naturally because DEPTH is a power of two.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wptr <= '0;
                rptr <= '0;
                cnt  <= '0;
            end else begin
                if (push[g]) wptr <= wptr + PTR_W'(1);
                if (pop[g])  rptr <= rptr + PTR_W'(1);
                cnt <= cnt + CNT_W'(push[g]) - CNT_W'(pop[g]);
            end
        end
    end

    // Round-robin pick: A wins a contest unless A was granted last.
    always_comb begin
        pop    = '0;
        pop[0] = nonempty[0] & (~nonempty[1] | (last_grant == SRC_B));
        pop[1] = nonempty[1] & ~pop[0];
    end

    // Registered write port and last-grant tracking; address/data hold when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_write   <= 1'b0;
            rd_addr    <= '0;
            rd_wdata   <= '0;
            last_grant <= SRC_B;
        end else begin
            rd_write <= |pop;
            if (pop[0]) begin
                rd_addr    <= head_addr[0];
                rd_wdata   <= head_data[0];
                last_grant <= SRC_A;
            end else if (pop[1]) begin
                rd_addr    <= head_addr[1];
                rd_wdata   <= head_data[1];
                last_grant <= SRC_B;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arb.sv
// Self-checking bench for regfile_wb_arb: directed scenarios followed by
// random traffic, all compared cycle by cycle against a queue-based model.
module tb_regfile_wb_arb;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              a_valid = 1'b0;
    logic              a_ready;
    logic [ADDR_W-1:0] a_addr = '0;
    logic [DATA_W-1:0] a_data = '0;
    logic              b_valid = 1'b0;
    logic              b_ready;
    logic [ADDR_W-1:0] b_addr = '0;
    logic [DATA_W-1:0] b_data = '0;
    logic              rd_write;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_wdata;
    logic              busy;

    regfile_wb_arb #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a_valid (a_valid),
        .a_ready (a_ready),
        .a_addr  (a_addr),
        .a_data  (a_data),
        .b_valid (b_valid),
        .b_ready (b_ready),
        .b_addr  (b_addr),
        .b_data  (b_data),
        .rd_write(rd_write),
        .rd_addr (rd_addr),
        .rd_wdata(rd_wdata),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Reference model: one queue per source, a "B granted last" flag,
    // and the expected state of the write port.
    logic [ADDR_W+DATA_W-1:0] qa[$];
    logic [ADDR_W+DATA_W-1:0] qb[$];
    logic                     last_b;
    logic                     exp_wr;
    logic [ADDR_W-1:0]        exp_addr;
    logic [DATA_W-1:0]        exp_data;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_clear();
        qa.delete();
        qb.delete();
        last_b   = 1'b1;
        exp_wr   = 1'b0;
        exp_addr = '0;
        exp_data = '0;
    endtask

    // One clock cycle: drive inputs, check readiness, advance the model, check outputs.
    task automatic cyc(input logic va, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] da,
                       input logic vb, input logic [ADDR_W-1:0] ab, input logic [DATA_W-1:0] db);
        logic ra, rb, ga, gb;
        a_valid = va; a_addr = aa; a_data = da;
        b_valid = vb; b_addr = ab; b_data = db;
        #1;
        ra = (qa.size() < DEPTH);
        rb = (qb.size() < DEPTH);
        chk("a_ready", 64'(a_ready), 64'(ra));
        chk("b_ready", 64'(b_ready), 64'(rb));
        ga = (qa.size() > 0) && ((qb.size() == 0) || last_b);
        gb = !ga && (qb.size() > 0);
        exp_wr = ga || gb;
        if (ga) begin
            {exp_addr, exp_data} = qa.pop_front();
            last_b = 1'b0;
        end else if (gb) begin
            {exp_addr, exp_data} = qb.pop_front();
            last_b = 1'b1;
        end
        if (va && ra) qa.push_back({aa, da});
        if (vb && rb) qb.push_back({ab, db});
        @(posedge clk);
        #1;
        chk("rd_write", 64'(rd_write), 64'(exp_wr));
        chk("rd_addr", 64'(rd_addr), 64'(exp_addr));
        chk("rd_wdata", 64'(rd_wdata), 64'(exp_data));
        chk("busy", 64'(busy), 64'((qa.size() + qb.size() > 0) || exp_wr));
    endtask

    task automatic idle();
        cyc(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    // Reset is asserted away from a clock edge; outputs must clear immediately.
    task automatic do_reset();
        a_valid = 1'b0;
        b_valid = 1'b0;
        rst_n   = 1'b0;
        #1;
        model_clear();
        chk("rst_rd_write", 64'(rd_write), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_a_ready", 64'(a_ready), 64'd1);
        chk("rst_b_ready", 64'(b_ready), 64'd1);
        chk("rst_rd_addr", 64'(rd_addr), 64'd0);
        chk("rst_rd_wdata", 64'(rd_wdata), 64'd0);
        @(posedge clk);
        #1;
        chk("rst_hold_rd_write", 64'(rd_write), 64'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        model_clear();
        do_reset();

        // Single write from A: appears only in the cycle after the second edge.
        cyc(1'b1, 4'd3, 32'hDEADBEEF, 1'b0, '0, '0);
        chk("no_bypass", 64'(rd_write), 64'd0);
        idle();
        chk("single_wr", 64'(rd_write), 64'd1);
        chk("single_addr", 64'(rd_addr), 64'd3);
        chk("single_data", 64'(rd_wdata), 64'hDEADBEEF);
        idle();
        chk("single_once", 64'(rd_write), 64'd0);
        chk("hold_addr", 64'(rd_addr), 64'd3);

        // Simultaneous first push after reset: A wins, then B.
        do_reset();
        cyc(1'b1, 4'd1, 32'h11, 1'b1, 4'd2, 32'h22);
        idle();
        chk("tie_first", 64'(rd_addr), 64'd1);
        idle();
        chk("tie_second", 64'(rd_addr), 64'd2);
        chk("tie_second_wr", 64'(rd_write), 64'd1);
        idle();

        // Same address from both with A granted last: B's value lands first.
        cyc(1'b1, 4'd7, 32'h77, 1'b0, '0, '0);
        idle();
        cyc(1'b1, 4'd5, 32'h5A, 1'b1, 4'd5, 32'h5B);
        idle();
        chk("dup_first", 64'(rd_wdata), 64'h5B);
        idle();
        chk("dup_last", 64'(rd_wdata), 64'h5A);
        idle();

        // A streams alone, then both stream: queues fill and grants alternate.
        for (int i = 0; i < 3; i++) cyc(1'b1, 4'(i), 32'hA000 + 32'(i), 1'b0, '0, '0);
        for (int i = 0; i < 8; i++)
            cyc(1'b1, 4'(8 + i), 32'hA100 + 32'(i), 1'b1, 4'(i), 32'hB100 + 32'(i));
        chk("stream_wr", 64'(rd_write), 64'd1);
        chk("stream_a_full", 64'(a_ready), 64'(qa.size() < DEPTH));
        for (int i = 0; i < 6; i++) idle();

        // Reset with entries queued: nothing stale may appear afterwards.
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 4'(i), 32'hC000 + 32'(i), 1'b1, 4'(i + 4), 32'hD000 + 32'(i));
        do_reset();
        for (int i = 0; i < 3; i++) idle();
        chk("post_rst_quiet", 64'(rd_write), 64'd0);

        // Random traffic.
        for (int i = 0; i < 400; i++)
            cyc(1'($urandom_range(0, 3) != 0), 4'($urandom), $urandom,
                1'($urandom_range(0, 3) != 0), 4'($urandom), $urandom);
        for (int i = 0; i < 6; i++) idle();
        chk("drained_busy", 64'(busy), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
